// File: rtl/attn_pkg.sv
// Shared types and the saturation helper for the attention dot-product engine.
package attn_pkg;

  typedef logic [0:0] state_t;
  localparam state_t GET_Q = 1'b0;
  localparam state_t GET_V = 1'b1;

  localparam int SAT_W = 64;

  // acc holds an acc_w-bit value in its low bits; the result is {clip flag, clamped value}.
  function automatic logic [SAT_W:0] sat_clip(input logic [SAT_W-1:0] acc,
                                              input int acc_w,
                                              input int out_w,
                                              input bit signed_mode);
    logic signed [SAT_W-1:0] ext;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    logic [SAT_W-1:0]        val;
    logic                    flag;
    ext = acc;
    for (int i = 0; i < SAT_W; i++) begin
      if (i >= acc_w) ext[i] = signed_mode ? acc[acc_w-1] : 1'b0;
    end
    if (signed_mode) begin
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
    end else begin
      hi = (64'sd1 <<< out_w) - 64'sd1;
      lo = 64'sd0;
    end
    val  = ext;
    flag = 1'b0;
    if (ext > hi) begin
      val  = hi;
      flag = 1'b1;
    end else if (ext < lo) begin
      val  = lo;
      flag = 1'b1;
    end
    return {flag, val};
  endfunction

endpackage

// File: rtl/attn_sat_shift.sv
// Combinational scale-and-clamp stage: shifts the accumulator right, then saturates to OUT_W.
module attn_sat_shift
  import attn_pkg::*;
#(
  parameter int ACC_W     = 18,
  parameter int OUT_W     = 8,
  parameter int SIGNED    = 1,
  parameter int OUT_SHIFT = 0
) (
  input  logic [ACC_W-1:0] acc_i,
  output logic [OUT_W-1:0] score_o,
  output logic             sat_o
);

  logic [ACC_W-1:0] shifted;
  logic [SAT_W:0]   clipped;
  logic             unusedClipBits;

  // Arithmetic shift floors toward -inf for signed sums; unsigned sums shift in zeros.
  always_comb begin
    shifted = acc_i >> OUT_SHIFT;
    if (SIGNED != 0) shifted = $signed(acc_i) >>> OUT_SHIFT;
  end

  assign clipped        = sat_clip(SAT_W'(shifted), ACC_W, OUT_W, SIGNED != 0);
  assign score_o        = clipped[OUT_W-1:0];
  assign sat_o          = clipped[SAT_W];
  assign unusedClipBits = ^clipped[SAT_W-1:OUT_W];

endmodule

// File: rtl/attn_dot_engine.sv
// Streaming q/v dot-product engine: accumulates VEC_LEN products and emits one
// scaled, saturated score per vector over a valid/ready master port.
module attn_dot_engine
  import attn_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int VEC_LEN   = 4,
  parameter int SIGNED    = 1,
  parameter int ACC_W     = 2 * DATA_W + $clog2(VEC_LEN),
  parameter int OUT_W     = 8,
  parameter int OUT_SHIFT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] qv_slv_in,
  input  logic              vld_slv_in,
  output logic              rdy_slv_out,
  output logic [OUT_W-1:0]  score_mst_out,
  output logic              vld_mst_out,
  input  logic              rdy_mst_in,
  output logic              sat_mst_out
);

  localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_ELEM = CNT_W'(VEC_LEN - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] q_q, q_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [OUT_W-1:0]  score_q, score_d;
  logic              sat_q, sat_d;
  logic              vld_q, vld_d;

  logic              beat;
  logic              lastV;
  logic              qSign, vSign;
  logic [ACC_W-1:0]  qExt, vExt, prod, accNxt;
  logic [OUT_W-1:0]  satScore;
  logic              satFlag;

  // Products are formed at full accumulator width so wrap-around keeps the signed result exact.
  assign qSign  = (SIGNED != 0) && q_q[DATA_W-1];
  assign vSign  = (SIGNED != 0) && qv_slv_in[DATA_W-1];
  assign qExt   = {{(ACC_W-DATA_W){qSign}}, q_q};
  assign vExt   = {{(ACC_W-DATA_W){vSign}}, qv_slv_in};
  assign prod   = qExt * vExt;
  assign accNxt = acc_q + prod;

  attn_sat_shift #(
    .ACC_W    (ACC_W),
    .OUT_W    (OUT_W),
    .SIGNED   (SIGNED),
    .OUT_SHIFT(OUT_SHIFT)
  ) u_sat_shift (
    .acc_i  (accNxt),
    .score_o(satScore),
    .sat_o  (satFlag)
  );

  // Only the final v beat can stall, and only when the previous score is still unclaimed.
  assign lastV       = (state_q == GET_V) && (cnt_q == LAST_ELEM);
  assign rdy_slv_out = !(lastV && vld_q && !rdy_mst_in);
  assign beat        = vld_slv_in && rdy_slv_out;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    acc_d   = acc_q;
    score_d = score_q;
    sat_d   = sat_q;
    vld_d   = vld_q;
    if (vld_q && rdy_mst_in) vld_d = 1'b0;
    if (beat) begin
      if (state_q == GET_Q) begin
        q_d     = qv_slv_in;
        state_d = GET_V;
      end else begin
        state_d = GET_Q;
        if (cnt_q != LAST_ELEM) begin
          acc_d = accNxt;
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          score_d = satScore;
          sat_d   = satFlag;
          vld_d   = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= GET_Q;
      cnt_q   <= '0;
      q_q     <= '0;
      acc_q   <= '0;
      score_q <= '0;
      sat_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      acc_q   <= acc_d;
      score_q <= score_d;
      sat_q   <= sat_d;
      vld_q   <= vld_d;
    end
  end

  assign score_mst_out = score_q;
  assign sat_mst_out   = sat_q;
  assign vld_mst_out   = vld_q;

endmodule
